rr_grant_encoder: RTL and testbench
===================================

Name: rr_grant_encoder

Overview:
- Round-robin arbiter that sits directly upstream of the 4-to-16 decoder.
- Takes 16 request lines and selects one requester. Emits its binary index and a valid/enable, which drive the decoder's i and en inputs.
- Holds each grant until the consumer acknowledges, the grant times out, or the requester withdraws.
- The decoder's one-hot output then becomes the system grant vector.

Parameters:
- N, 16, number of requesters; must equal 2**IDX_W.
- IDX_W, 4, index width; matches decoder select width.
- MAX_HOLD, 15, maximum cycles a grant may stay up without ack; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  N  request vector; bit k set = requester k wants service.
- ack  input  1  consumer done with current grant; sampled only while gnt_vld=1.
- gnt_vld  output  1  grant valid; drives decoder en.
- gnt_idx  output  IDX_W  granted requester index; drives decoder i.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, rst=1):
  - State = IDLE, ptr = 0, hold_cnt = 0.
  - gnt_vld = 0, gnt_idx = 0, timeout = 0, busy = 0.
- States:
  - IDLE: no grant outstanding.
  - GRANT: gnt_vld=1 with a stable gnt_idx.
- Selection function pick(mask, ptr): the lowest index k ≥ ptr with mask[k]=1. If there is none, the lowest k < ptr with mask[k]=1 (wrap-around search).
- IDLE transition: if req != 0 at a clock edge, then next cycle:
  - State = GRANT, gnt_vld = 1, gnt_idx = pick(req, ptr), hold_cnt = 0.
  - Latency is one cycle from req assertion to gnt_vld.
- GRANT: gnt_idx is held constant. hold_cnt increments each cycle and saturates at MAX_HOLD.
- Release events in GRANT, evaluated in this priority order:
  1. ack=1: normal release.
  2. req[gnt_idx]=0: withdraw; release without ack.
  3. MAX_HOLD != 0 and hold_cnt = MAX_HOLD-1 and no ack: timeout. The timeout pulse is asserted in the following cycle, together with the release.
- On any release:
  - ptr <= gnt_idx+1, modulo N; 15 wraps to 0.
  - Let rem = req & ~(1<<gnt_idx).
  - If rem != 0: stay in GRANT with gnt_idx = pick(rem, gnt_idx+1) and hold_cnt = 0. This gives a back-to-back grant with no idle bubble.
  - Else: go to IDLE with gnt_vld = 0. gnt_idx keeps its last value.
- ack asserted in IDLE is ignored.
- ack and timeout condition in the same cycle: ack wins, and no timeout pulse is issued.
- gnt_vld is never high with an index whose req bit was 0 at the selection edge.
- Fairness: after requester k is served, every other active requester is served before k again.
- rst asserted mid-GRANT: gnt_vld drops immediately (asynchronously) and ptr returns to 0.

Decomposition:
- Shared package rr_pkg holds:
  - Localparams N and IDX_W.
  - typedef enum logic {IDLE, GRANT} rr_state_t.
  - typedef logic [IDX_W-1:0] idx_t.
- One sub-module is natural: rr_pick, a combinational wrap-around priority finder (mask, ptr -> idx, found).
- The top-level holds the FSM, the ptr register and the hold counter.
- The decoder's interface gains clk/rst for this stage; the top bench connects gnt_vld->en and gnt_idx->i.

Test Plan:
- Reset then req=16'h0001 -> gnt_vld=1, gnt_idx=0 one cycle later; decoder y=16'h0001.
- req=16'h8001 held, ack pulsed each grant -> gnt_idx sequence 0,15,0,15; no idle cycle between grants.
- ptr=14 (after serving 13), req=16'h0009 -> gnt_idx=0, then 3; wrap-around verified.
- MAX_HOLD=4, req=16'h0020, ack never asserted:
  - gnt_idx=5 for 4 cycles, then a timeout pulse.
  - With req still high, gnt_idx=5 is re-granted (sole requester).
- Grant on idx 2, then req[2] drops with no ack -> release; req=16'h0110 remaining gives gnt_idx=4 next cycle, timeout=0.
- rst asserted while gnt_vld=1 -> gnt_vld=0 within the same cycle (async); after release with req=16'h0006 -> gnt_idx=1 (ptr reset to 0).

Source files
------------

// File: rtl/rr_pkg.sv
// Shared types and sizing for the round-robin grant encoder and its
// wrap-around priority finder.
package rr_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } rr_state_t;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational wrap-around priority finder: lowest set bit of mask at or
// above ptr, otherwise the lowest set bit below ptr.
module rr_pick
  import rr_pkg::*;
(
  input  logic [N-1:0] mask_i,
  input  idx_t         ptr_i,
  output idx_t         idx_o,
  output logic         found_o
);

  idx_t cand;

  // Walk offsets from the far end so the smallest offset from ptr wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr_i + idx_t'(i);
      if (mask_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter producing a binary grant index and valid that feed a
// 4-to-16 decoder; grants are held until ack, withdraw or hold timeout.
module rr_grant_encoder
  import rr_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         ack_i,
  output logic         gnt_vld_o,
  output idx_t         gnt_idx_o,
  output logic         timeout_o,
  output logic         busy_o
);

  localparam int unsigned CntW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] HoldMax  = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] HoldLast = CntW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit TimeoutEn = (MAX_HOLD != 0);

  rr_state_t       state_q, state_d;
  idx_t            ptr_q, ptr_d;
  idx_t            idx_q, idx_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic            timeout_q, timeout_d;

  logic [N-1:0] rem;
  idx_t         idle_idx, rem_idx, idx_inc;
  logic         idle_found, rem_found;
  logic         withdraw, to_hit, release_ev;

  assign idx_inc = idx_q + idx_t'(1);
  assign rem     = req_i & ~(N'(1) << idx_q);

  rr_pick u_pick_idle (
    .mask_i  (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (idle_idx),
    .found_o (idle_found)
  );

  // Back-to-back search starts just past the current holder.
  rr_pick u_pick_rem (
    .mask_i  (rem),
    .ptr_i   (idx_inc),
    .idx_o   (rem_idx),
    .found_o (rem_found)
  );

  assign withdraw   = ~req_i[idx_q];
  assign to_hit     = TimeoutEn && (hold_q == HoldLast);
  assign release_ev = ack_i | withdraw | to_hit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (idle_found) begin
          state_d = GRANT;
          idx_d   = idle_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_ev) begin
          // Timeout only counts when neither ack nor withdraw claimed the release.
          timeout_d = to_hit & ~ack_i & ~withdraw;
          ptr_d     = idx_inc;
          hold_d    = '0;
          if (rem_found) begin
            idx_d = rem_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_vld_o = (state_q == GRANT);
  assign busy_o    = (state_q != IDLE);
  assign gnt_idx_o = idx_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Scoreboard bench for rr_grant_encoder built with MAX_HOLD = 4; the grant
// outputs also drive a behavioural 4-to-16 decoder.
module tb_rr_grant_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        ack;
  logic        gnt_vld;
  logic [3:0]  gnt_idx;
  logic        timeout;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      tag;
    logic       vld;
    logic [3:0] idx;
    logic       to;
  } exp_t;

  exp_t sb_q[$];

  rr_grant_encoder #(
    .MAX_HOLD (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .ack_i     (ack),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dec(input logic en, input logic [3:0] i);
    logic [15:0] one;
    one = 16'h0001;
    return en ? (one << i) : 16'h0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, queue the expected outputs, compare after the edge.
  task automatic step(input string tag, input logic [15:0] r, input logic a,
                      input logic e_vld, input logic [3:0] e_idx, input logic e_to);
    exp_t e;
    exp_t got;
    req = r;
    ack = a;
    e.tag = tag;
    e.vld = e_vld;
    e.idx = e_idx;
    e.to  = e_to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_eq({got.tag, ".vld"}, 32'(gnt_vld), 32'(got.vld));
      check_eq({got.tag, ".idx"}, 32'(gnt_idx), 32'(got.idx));
      check_eq({got.tag, ".to"}, 32'(timeout), 32'(got.to));
      check_eq({got.tag, ".busy"}, 32'(busy), 32'(got.vld));
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, ".rst_vld"}, 32'(gnt_vld), 32'd0);
    check_eq({tag, ".rst_idx"}, 32'(gnt_idx), 32'd0);
    check_eq({tag, ".rst_to"}, 32'(timeout), 32'd0);
    check_eq({tag, ".rst_busy"}, 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ack = 1'b0;

    // Single request, one-cycle latency, decoder output.
    do_reset("r0");
    step("single", 16'h0001, 1'b0, 1'b1, 4'd0, 1'b0);
    check_eq("single.dec_y", 32'(dec(gnt_vld, gnt_idx)), 32'h0001);
    step("single_ack", 16'h0001, 1'b1, 1'b0, 4'd0, 1'b0);

    // Two requesters alternate with no idle bubble.
    do_reset("r1");
    step("alt0", 16'h8001, 1'b0, 1'b1, 4'd0, 1'b0);
    step("alt1", 16'h8001, 1'b1, 1'b1, 4'd15, 1'b0);
    step("alt2", 16'h8001, 1'b1, 1'b1, 4'd0, 1'b0);
    step("alt3", 16'h8001, 1'b1, 1'b1, 4'd15, 1'b0);
    check_eq("alt3.dec_y", 32'(dec(gnt_vld, gnt_idx)), 32'h8000);
    step("alt_end", 16'h0000, 1'b1, 1'b0, 4'd15, 1'b0);

    // Serve 13 so ptr=14, then wrap-around to 0 and 3.
    step("wrap13", 16'h2000, 1'b0, 1'b1, 4'd13, 1'b0);
    step("wrap0", 16'h0009, 1'b1, 1'b1, 4'd0, 1'b0);
    step("wrap3", 16'h0009, 1'b1, 1'b1, 4'd3, 1'b0);
    step("wrap_end", 16'h0000, 1'b1, 1'b0, 4'd3, 1'b0);
    step("idle_ack", 16'h0000, 1'b1, 1'b0, 4'd3, 1'b0);

    // Hold timeout after 4 granted cycles, then sole requester re-granted.
    do_reset("r2");
    step("to_h0", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("to_h1", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("to_h2", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("to_h3", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("to_pulse", 16'h0020, 1'b0, 1'b0, 4'd5, 1'b1);
    step("to_regrant", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("to_drop", 16'h0000, 1'b0, 1'b0, 4'd5, 1'b0);

    // Withdraw without ack moves straight to the next requester.
    do_reset("r3");
    step("wd_g2", 16'h0114, 1'b0, 1'b1, 4'd2, 1'b0);
    step("wd_g4", 16'h0110, 1'b0, 1'b1, 4'd4, 1'b0);
    step("wd_g8", 16'h0110, 1'b1, 1'b1, 4'd8, 1'b0);
    step("wd_end", 16'h0000, 1'b1, 1'b0, 4'd8, 1'b0);

    // Async reset mid-grant, then ptr back at 0 (ptr 9 would pick 9 here).
    step("ar_g6", 16'h0040, 1'b0, 1'b1, 4'd6, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("ar.async_vld", 32'(gnt_vld), 32'd0);
    check_eq("ar.async_busy", 32'(busy), 32'd0);
    check_eq("ar.async_idx", 32'(gnt_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("ar_g1", 16'h0206, 1'b0, 1'b1, 4'd1, 1'b0);
    step("ar_end", 16'h0000, 1'b0, 1'b0, 4'd1, 1'b0);

    // Ack coinciding with the timeout cycle: ack wins, no pulse.
    do_reset("r4");
    step("at_h0", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("at_h1", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("at_h2", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("at_h3", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    step("at_ack", 16'h0020, 1'b1, 1'b0, 4'd5, 1'b0);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
